sa_instr_decoder: RTL and testbench

Parametrised instruction decoder and stream sequencer for the systolic array. It sits between the host instruction port and the input, weight and output buffers, the MAC array and the accumulators. It accepts one instruction per valid/ready handshake and emits registered single-cycle buffer writes and control strobes. For the multi-cycle opcodes (MAC, send weights) it runs a counted streaming burst, holding off new instructions until the burst completes.

---
 rtl/sa_instr_decoder.sv | 208 ++++++++++++++++++++
 tb/tb_sa_instr_decoder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sa_instr_decoder.sv
// sa_instr_decoder: host instruction decoder and stream sequencer for the
// systolic array. One instruction is accepted per valid/ready handshake. The
// decoded buffer write or control strobe is registered and appears one cycle
// later. MAC and send-weights run a counted streaming burst. New instructions
// are held off until the burst completes.
// Optional feature: define SA_DEC_ERR_CHECK_EN to flag illegal opcodes on
// the sticky err_opcode output. Otherwise err_opcode is tied to 0.
module sa_instr_decoder #(
  parameter int ADDR_W      = 14,
  parameter int DATA_W      = 32,
  parameter int OBUF_ADDR_W = 4,
  parameter int CNT_W       = 8,
  parameter int INSTR_W     = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [INSTR_W-1:0]     instr,
  input  logic                   instr_valid,
  output logic                   instr_ready,
  output logic                   inp_buf_we,
  output logic [ADDR_W-1:0]      inp_buf_addr,
  output logic [DATA_W-1:0]      inp_buf_data,
  output logic                   wt_buf_we,
  output logic [ADDR_W-1:0]      wt_buf_addr,
  output logic [DATA_W-1:0]      wt_buf_data,
  output logic                   stream_en,
  output logic [CNT_W-1:0]       stream_idx,
  output logic                   i_mode,
  output logic                   acc_result_to_op_buf,
  output logic [OBUF_ADDR_W-1:0] acc_to_op_buf_addr,
  output logic                   op_buf_send,
  output logic [OBUF_ADDR_W-1:0] out_buf_addr,
  output logic                   acc_reset,
  output logic                   err_opcode
);

  // Field positions, packed MSB first. Any spare LSBs are ignored.
  localparam int OP_LSB   = INSTR_W - 5;
  localparam int ADDR_LSB = OP_LSB - ADDR_W;
  localparam int DATA_LSB = ADDR_LSB - DATA_W;
  localparam int CNT_LSB  = DATA_LSB - CNT_W;

  localparam logic [4:0] OP_NOP0  = 5'b00000;
  localparam logic [4:0] OP_MAC   = 5'b00001;
  localparam logic [4:0] OP_SENDW = 5'b00010;
  localparam logic [4:0] OP_ACCST = 5'b00011;
  localparam logic [4:0] OP_INPWR = 5'b00100;
  localparam logic [4:0] OP_WTWR  = 5'b00101;
  localparam logic [4:0] OP_OSEND = 5'b00110;
  localparam logic [4:0] OP_ACCRS = 5'b00111;
  localparam logic [4:0] OP_NOP1  = 5'b11111;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t state, state_d;
  logic [CNT_W-1:0] last_q, last_d;  // index of the final beat (N-1)

  logic [4:0]        f_op;
  logic [ADDR_W-1:0] f_addr;
  logic [DATA_W-1:0] f_data;
  logic [CNT_W-1:0]  f_cnt;

  assign f_op   = instr[INSTR_W-1 -: 5];
  assign f_addr = instr[ADDR_LSB +: ADDR_W];
  assign f_data = instr[DATA_LSB +: DATA_W];
  assign f_cnt  = instr[CNT_LSB +: CNT_W];

  // Spare LSBs and the upper address bits for the output buffer are not
  // decoded. This reduction only keeps them from looking like dangling logic.
  logic unused_instr;
  assign unused_instr = ^instr;

  logic                   ready_d, inp_we_d, wt_we_d, sen_d, imode_d;
  logic                   accst_d, osend_d, accrs_d, err_set;
  logic [ADDR_W-1:0]      inp_addr_d, wt_addr_d;
  logic [DATA_W-1:0]      inp_data_d, wt_data_d;
  logic [CNT_W-1:0]       idx_d;
  logic [OBUF_ADDR_W-1:0] accst_addr_d, osend_addr_d;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      last_q <= '0;
    end else begin
      state  <= state_d;
      last_q <= last_d;
    end
  end

  // Next state and next-cycle outputs. Strobes default to 0 so they pulse for one cycle.
  always_comb begin
    state_d      = state;
    last_d       = last_q;
    inp_we_d     = 1'b0;
    inp_addr_d   = '0;
    inp_data_d   = '0;
    wt_we_d      = 1'b0;
    wt_addr_d    = '0;
    wt_data_d    = '0;
    sen_d        = 1'b0;
    idx_d        = '0;
    imode_d      = 1'b0;
    accst_d      = 1'b0;
    accst_addr_d = '0;
    osend_d      = 1'b0;
    osend_addr_d = '0;
    accrs_d      = 1'b0;
    err_set      = 1'b0;
    case (state)
      IDLE: begin
        if (instr_valid) begin
          case (f_op)
            OP_NOP0, OP_NOP1: ;
            OP_MAC, OP_SENDW: begin
              state_d = STREAM;
              sen_d   = 1'b1;
              imode_d = (f_op == OP_SENDW);
              // count==0 still runs a single beat
              last_d  = (f_cnt == '0) ? '0 : f_cnt - CNT_W'(1);
            end
            OP_ACCST: begin
              accst_d      = 1'b1;
              accst_addr_d = f_addr[OBUF_ADDR_W-1:0];
            end
            OP_INPWR: begin
              inp_we_d   = 1'b1;
              inp_addr_d = f_addr;
              inp_data_d = f_data;
            end
            OP_WTWR: begin
              wt_we_d   = 1'b1;
              wt_addr_d = f_addr;
              wt_data_d = f_data;
            end
            OP_OSEND: begin
              osend_d      = 1'b1;
              osend_addr_d = f_addr[OBUF_ADDR_W-1:0];
            end
            OP_ACCRS: accrs_d = 1'b1;
            default:  err_set = 1'b1;
          endcase
        end
      end
      STREAM: begin
        if (stream_idx == last_q) begin
          state_d = IDLE;
        end else begin
          sen_d   = 1'b1;
          idx_d   = stream_idx + CNT_W'(1);
          imode_d = i_mode;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  // Output registers. Reset forces everything quiet and ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_ready          <= 1'b1;
      inp_buf_we           <= 1'b0;
      inp_buf_addr         <= '0;
      inp_buf_data         <= '0;
      wt_buf_we            <= 1'b0;
      wt_buf_addr          <= '0;
      wt_buf_data          <= '0;
      stream_en            <= 1'b0;
      stream_idx           <= '0;
      i_mode               <= 1'b0;
      acc_result_to_op_buf <= 1'b0;
      acc_to_op_buf_addr   <= '0;
      op_buf_send          <= 1'b0;
      out_buf_addr         <= '0;
      acc_reset            <= 1'b0;
    end else begin
      instr_ready          <= ready_d;
      inp_buf_we           <= inp_we_d;
      inp_buf_addr         <= inp_addr_d;
      inp_buf_data         <= inp_data_d;
      wt_buf_we            <= wt_we_d;
      wt_buf_addr          <= wt_addr_d;
      wt_buf_data          <= wt_data_d;
      stream_en            <= sen_d;
      stream_idx           <= idx_d;
      i_mode               <= imode_d;
      acc_result_to_op_buf <= accst_d;
      acc_to_op_buf_addr   <= accst_addr_d;
      op_buf_send          <= osend_d;
      out_buf_addr         <= osend_addr_d;
      acc_reset            <= accrs_d;
    end
  end

`ifdef SA_DEC_ERR_CHECK_EN
  // Sticky illegal-opcode flag. Only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_opcode <= 1'b0;
    else if (err_set) err_opcode <= 1'b1;
  end
`else
  logic unused_err;
  assign unused_err = err_set;
  assign err_opcode = 1'b0;
`endif

endmodule

// File: tb/tb_sa_instr_decoder.sv
// Bench for sa_instr_decoder. The reference model keeps a per-cycle schedule
// of expected outputs. Each accepted instruction writes the cycles in which
// its strobe or burst beats must appear. A per-cycle compare process checks
// the DUT against that schedule. Directed sections pin the model with literal values.
module tb_sa_instr_decoder;
  localparam int ADDR_W = 14, DATA_W = 32, OBUF_ADDR_W = 4, CNT_W = 8, INSTR_W = 64;
`ifdef SA_DEC_ERR_CHECK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic [INSTR_W-1:0] instr = '0;
  logic instr_valid = 1'b0;
  logic instr_ready, inp_buf_we, wt_buf_we, stream_en, i_mode;
  logic acc_result_to_op_buf, op_buf_send, acc_reset, err_opcode;
  logic [ADDR_W-1:0] inp_buf_addr, wt_buf_addr;
  logic [DATA_W-1:0] inp_buf_data, wt_buf_data;
  logic [CNT_W-1:0] stream_idx;
  logic [OBUF_ADDR_W-1:0] acc_to_op_buf_addr, out_buf_addr;

  sa_instr_decoder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .OBUF_ADDR_W(OBUF_ADDR_W),
                     .CNT_W(CNT_W), .INSTR_W(INSTR_W)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .inp_buf_we(inp_buf_we), .inp_buf_addr(inp_buf_addr),
    .inp_buf_data(inp_buf_data), .wt_buf_we(wt_buf_we), .wt_buf_addr(wt_buf_addr),
    .wt_buf_data(wt_buf_data), .stream_en(stream_en), .stream_idx(stream_idx),
    .i_mode(i_mode), .acc_result_to_op_buf(acc_result_to_op_buf),
    .acc_to_op_buf_addr(acc_to_op_buf_addr), .op_buf_send(op_buf_send),
    .out_buf_addr(out_buf_addr), .acc_reset(acc_reset), .err_opcode(err_opcode));

  always #5 clk = ~clk;

  typedef struct packed {
    logic inp_we; logic [ADDR_W-1:0] inp_addr; logic [DATA_W-1:0] inp_data;
    logic wt_we;  logic [ADDR_W-1:0] wt_addr;  logic [DATA_W-1:0] wt_data;
    logic sen; logic [CNT_W-1:0] idx; logic imode;
    logic accst; logic [OBUF_ADDR_W-1:0] accst_addr;
    logic osend; logic [OBUF_ADDR_W-1:0] osend_addr;
    logic accrs;
  } exp_t;

  int checks = 0, errors = 0;
  exp_t sched[int];
  int cyc = 0, busy_until = -1, err_cyc = 32'h7fffffff;
  logic acc_flag = 1'b0;
  exp_t e, act;
  logic rdy;

  task automatic chk(input string name, input logic [127:0] a, input logic [127:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, a, x, $time);
    end
  endtask

  function automatic logic [INSTR_W-1:0] mk(input logic [4:0] op, input logic [ADDR_W-1:0] a,
                                            input logic [DATA_W-1:0] d, input logic [CNT_W-1:0] c);
    return {op, a, d, c, {(INSTR_W-5-ADDR_W-DATA_W-CNT_W){1'b0}}};
  endfunction

  // Model: schedule the effect of an instruction accepted at the end of cycle t.
  task automatic model_accept(input int t);
    logic [4:0] op; logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d; int n;
    exp_t s;
    op = instr[63:59]; a = instr[58:45]; d = instr[44:13]; n = int'(instr[12:5]);
    s = '0;
    if (op == 5'd1 || op == 5'd2) begin
      if (n == 0) n = 1;
      for (int k = 0; k < n; k++) begin
        s = '0; s.sen = 1'b1; s.idx = CNT_W'(k); s.imode = (op == 5'd2);
        sched[t + 1 + k] = s;
      end
      busy_until = t + n;
    end else begin
      case (op)
        5'd3: begin s.accst = 1'b1; s.accst_addr = a[3:0]; end
        5'd4: begin s.inp_we = 1'b1; s.inp_addr = a; s.inp_data = d; end
        5'd5: begin s.wt_we = 1'b1; s.wt_addr = a; s.wt_data = d; end
        5'd6: begin s.osend = 1'b1; s.osend_addr = a[3:0]; end
        5'd7: s.accrs = 1'b1;
        5'd0, 5'd31: ;
        default: if (ERR_EN && err_cyc > t + 1) err_cyc = t + 1;
      endcase
      sched[t + 1] = s;
    end
  endtask

  // Compare DUT with the model every cycle, then apply any handshake in this cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      sched.delete(); busy_until = -1; err_cyc = 32'h7fffffff;
      e = '0; rdy = 1'b1;
    end else begin
      e = sched.exists(cyc) ? sched[cyc] : '0;
      if (sched.exists(cyc)) sched.delete(cyc);
      rdy = (cyc > busy_until);
    end
    act = '{inp_buf_we, inp_buf_addr, inp_buf_data, wt_buf_we, wt_buf_addr, wt_buf_data,
            stream_en, stream_idx, i_mode, acc_result_to_op_buf, acc_to_op_buf_addr,
            op_buf_send, out_buf_addr, acc_reset};
    chk("outputs", 128'(act), 128'(e));
    chk("instr_ready", 128'(instr_ready), 128'(rdy));
    chk("err_opcode", 128'(err_opcode), 128'(rst_n && cyc >= err_cyc));
    acc_flag = rst_n && instr_valid && rdy;
    if (acc_flag) model_accept(cyc);
    cyc++;
  end

  // Present one instruction and hold it until accepted. Call and return at posedge+1.
  task automatic send(input logic [4:0] op, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d, input logic [CNT_W-1:0] c);
    bit ok = 0;
    instr = mk(op, a, d, c); instr_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (acc_flag) begin ok = 1; break; end
    end
    if (!ok) chk("accept_timeout", 128'(0), 128'(1));
    instr_valid = 1'b0;
  endtask

  task automatic reset_pulse();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_stream_en", 128'(stream_en), 128'(0));
    chk("rst_stream_idx", 128'(stream_idx), 128'(0));
    chk("rst_i_mode", 128'(i_mode), 128'(0));
    chk("rst_ready", 128'(instr_ready), 128'(1));
    chk("rst_err", 128'(err_opcode), 128'(0));
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", 128'(instr_ready), 128'(1));
    chk("reset_stream_en", 128'(stream_en), 128'(0));
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Input-buffer write: one-cycle pulse with literal address and data.
    send(5'b00100, 14'h1A5, 32'hDEADBEEF, 8'd0);
    chk("inp_we", 128'(inp_buf_we), 128'(1));
    chk("inp_addr", 128'(inp_buf_addr), 128'h1A5);
    chk("inp_data", 128'(inp_buf_data), 128'hDEADBEEF);
    @(posedge clk); #1;
    chk("inp_we_off", 128'(inp_buf_we), 128'(0));
    chk("inp_data_off", 128'(inp_buf_data), 128'(0));

    // Weight burst of 4 with acc_reset waiting behind it.
    send(5'b00010, 14'h0, 32'h0, 8'd4);
    instr = mk(5'b00111, 14'h0, 32'h0, 8'd0); instr_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("sw_en", 128'(stream_en), 128'(1));
      chk("sw_idx", 128'(stream_idx), 128'(k));
      chk("sw_imode", 128'(i_mode), 128'(1));
      chk("sw_ready", 128'(instr_ready), 128'(0));
      @(posedge clk); #1;
    end
    chk("sw_ready_back", 128'(instr_ready), 128'(1));
    chk("sw_en_off", 128'(stream_en), 128'(0));
    @(posedge clk); #1;
    instr_valid = 1'b0;
    chk("acc_reset", 128'(acc_reset), 128'(1));
    @(posedge clk); #1;

    // MAC with count 0: a single beat.
    send(5'b00001, 14'h0, 32'h0, 8'd0);
    chk("mac0_en", 128'(stream_en), 128'(1));
    chk("mac0_idx", 128'(stream_idx), 128'(0));
    chk("mac0_imode", 128'(i_mode), 128'(0));
    @(posedge clk); #1;
    chk("mac0_en_off", 128'(stream_en), 128'(0));
    chk("mac0_ready", 128'(instr_ready), 128'(1));

    // Back-to-back single-cycle opcodes.
    send(5'b00011, 14'h3, 32'h0, 8'd0);
    chk("b2b_accst", 128'({acc_result_to_op_buf, acc_to_op_buf_addr}), 128'h13);
    send(5'b00110, 14'h7, 32'h0, 8'd0);
    chk("b2b_osend", 128'({op_buf_send, out_buf_addr}), 128'h17);
    send(5'b00101, 14'h10, 32'h5, 8'd0);
    chk("b2b_wt", 128'({wt_buf_we, wt_buf_addr, wt_buf_data}), {95'd0, 1'b1, 14'h10, 32'h5});

    // Long MAC aborted by reset at beat 50.
    send(5'b00001, 14'h0, 32'h0, 8'd200);
    repeat (50) @(posedge clk);
    #1 chk("abort_idx", 128'(stream_idx), 128'd50);
    reset_pulse();
    repeat (4) begin
      chk("post_abort_en", 128'(stream_en), 128'(0));
      @(posedge clk); #1;
    end

    // Illegal opcode.
    chk("err_before", 128'(err_opcode), 128'(0));
    send(5'b01010, 14'h0, 32'h0, 8'd0);
    chk("err_after", 128'(err_opcode), 128'(ERR_EN));
    @(posedge clk); #1;
    chk("err_sticky", 128'(err_opcode), 128'(ERR_EN));
    reset_pulse();

    // Randomized traffic against the schedule model.
    for (int i = 0; i < 250; i++) begin
      int gap, r;
      logic [4:0] op;
      gap = $urandom_range(0, 2);
      repeat (gap) begin @(posedge clk); #1; end
      r = $urandom_range(0, 9);
      op = (r < 2) ? 5'd1 : (r < 4) ? 5'd2 : (r < 8) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      send(op, 14'($urandom), $urandom, ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 12)));
    end
    repeat (20) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
